// File: rtl/cache_refill_ctrl_if.sv
// Memory read port of the refill controller: one request/grant handshake followed by
// rvalid-qualified read beats.
interface cache_refill_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic [31:0]       mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// 2-way cache miss refill controller: victim select, invalidate, 4-beat line fetch, tag commit.
// Optional macro CRITICAL_WORD_FIRST_EN fetches the missed word first and wraps the line.
module cache_refill_ctrl #(
  parameter int TAG_W  = 28,
  parameter int DATA_W = 32,
  parameter int BEATS  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                miss_valid,
  input  logic [31:0]         miss_addr,
  input  logic                lookup_valid,
  input  logic                hit0,
  input  logic                hit1,
  input  logic                v_way0,
  input  logic                v_way1,
  output logic                busy,
  output logic                victim_way,
  output logic [1:0]          way_we,
  output logic [TAG_W-1:0]    way_tag,
  output logic                way_valid,
  output logic                data_we,
  output logic [1:0]          data_idx,
  output logic [DATA_W-1:0]   data_wdata,
  output logic                crit_valid,
  output logic [DATA_W-1:0]   crit_data,
  output logic                refill_done,
  cache_refill_ctrl_if.master mem
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INVAL,
    S_REQ,
    S_FILL,
    S_COMMIT
  } state_e;

  state_e      state, state_nxt;
  logic [31:2] addr_q;
  logic        victim_q;
  logic        lru;
  logic [1:0]  beat_q;
  logic        victim_sel;
  logic        last_beat;
  logic        unused_addr_bits;

  // Byte offset within a word never affects the refill.
  assign unused_addr_bits = ^miss_addr[1:0];

  // Empty ways are always filled first; LRU only arbitrates when both are valid.
  assign victim_sel = !v_way0 ? 1'b0 : (!v_way1 ? 1'b1 : lru);
  assign last_beat  = (beat_q == 2'(BEATS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; this is what lets a coincident miss use the old LRU bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (miss_valid) state_nxt = S_INVAL;
      S_INVAL:  state_nxt = S_REQ;
      S_REQ:    if (mem.mem_gnt) state_nxt = S_FILL;
      S_FILL:   if (mem.mem_rvalid && last_beat) state_nxt = S_COMMIT;
      S_COMMIT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != S_IDLE);
    way_we      = 2'b00;
    way_valid   = 1'b0;
    mem.mem_req = 1'b0;
    data_we     = 1'b0;
    refill_done = 1'b0;
    case (state)
      S_INVAL:  way_we = victim_q ? 2'b10 : 2'b01;
      S_REQ:    mem.mem_req = 1'b1;
      S_FILL:   data_we = mem.mem_rvalid;
      S_COMMIT: begin
        way_we      = victim_q ? 2'b10 : 2'b01;
        way_valid   = 1'b1;
        refill_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      victim_q <= 1'b0;
      lru      <= 1'b0;
      beat_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          beat_q <= '0;
          if (miss_valid) begin
            addr_q   <= miss_addr[31:2];
            victim_q <= victim_sel;
          end
          // A double hit carries no recency information, so it leaves LRU alone.
          if (lookup_valid && (hit0 ^ hit1)) lru <= hit0;
        end
        S_FILL:   if (mem.mem_rvalid) beat_q <= beat_q + 2'd1;
        S_COMMIT: lru <= ~victim_q;
        default: ;
      endcase
    end
  end

  assign victim_way = victim_q;
  assign way_tag    = addr_q[31:32-TAG_W];
  assign data_wdata = mem.mem_rdata;
  assign crit_data  = mem.mem_rdata;

`ifdef CRITICAL_WORD_FIRST_EN
  assign mem.mem_addr = {addr_q, 2'b00};
  assign data_idx     = addr_q[3:2] + beat_q;
  assign crit_valid   = data_we && (beat_q == 2'd0);
`else
  assign mem.mem_addr = {addr_q[31:4], 4'b0000};
  assign data_idx     = beat_q;
  assign crit_valid   = data_we && (beat_q == addr_q[3:2]);
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed testbench for cache_refill_ctrl; expected values follow the refill protocol
// and honour CRITICAL_WORD_FIRST_EN when defined.
module tb_cache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_valid, lookup_valid, hit0, hit1, v_way0, v_way1;
  logic [31:0] miss_addr;
  logic        busy, victim_way, way_valid, data_we, crit_valid, refill_done;
  logic [1:0]  way_we, data_idx;
  logic [27:0] way_tag;
  logic [31:0] data_wdata, crit_data;

  int checks   = 0;
  int failures = 0;
  int we_cnt   = 0;
  int crit_cnt = 0;
  logic exp_lru = 1'b0;

  cache_refill_ctrl_if #(.DATA_W(32)) mem_bus ();

  cache_refill_ctrl dut (
    .clk(clk), .rst_n(rst_n), .miss_valid(miss_valid), .miss_addr(miss_addr),
    .lookup_valid(lookup_valid), .hit0(hit0), .hit1(hit1), .v_way0(v_way0), .v_way1(v_way1),
    .busy(busy), .victim_way(victim_way), .way_we(way_we), .way_tag(way_tag),
    .way_valid(way_valid), .data_we(data_we), .data_idx(data_idx), .data_wdata(data_wdata),
    .crit_valid(crit_valid), .crit_data(crit_data), .refill_done(refill_done),
    .mem(mem_bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (data_we)    we_cnt++;
    if (crit_valid) crit_cnt++;
  end

  function automatic logic [1:0] exp_idx(input logic [31:0] a, input int k);
`ifdef CRITICAL_WORD_FIRST_EN
    return a[3:2] + k[1:0];
`else
    return k[1:0];
`endif
  endfunction

  function automatic logic exp_crit(input logic [31:0] a, input int k);
`ifdef CRITICAL_WORD_FIRST_EN
    return k == 0;
`else
    return k[1:0] == a[3:2];
`endif
  endfunction

  function automatic logic [31:0] exp_maddr(input logic [31:0] a);
`ifdef CRITICAL_WORD_FIRST_EN
    return {a[31:2], 2'b00};
`else
    return {a[31:4], 4'b0000};
`endif
  endfunction

  function automatic logic exp_victim(input logic v0, input logic v1);
    return !v0 ? 1'b0 : (!v1 ? 1'b1 : exp_lru);
  endfunction

  // Drives a miss at the next edge; returns at the negedge inside INVAL.
  task automatic start_miss(input logic [31:0] a, input logic v0, input logic v1, input logic gnt);
    @(negedge clk);
    miss_addr = a; miss_valid = 1'b1; v_way0 = v0; v_way1 = v1; mem_bus.mem_gnt = gnt;
    @(negedge clk);
    miss_valid = 1'b0;
  endtask

  // Drives beats k0..k1-1 from a FILL-state negedge; an idle cycle precedes beat gap_at.
  task automatic drive_fill(input logic [31:0] a, input logic [31:0] seed,
                            input int k0, input int k1, input int gap_at);
    for (int k = k0; k < k1; k++) begin
      logic [31:0] d;
      d = 32'(seed * (k + 1));
      if (k == gap_at) begin
        mem_bus.mem_rvalid = 1'b0; #1;
        checks++;
        if (data_we !== 1'b0) begin
          failures++; $display("FAIL gap_data_we: got %b want 0", data_we);
        end
        @(negedge clk);
      end
      mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = d; #1;
      checks++;
      if (data_we !== 1'b1 || data_idx !== exp_idx(a, k) || data_wdata !== d) begin
        failures++;
        $display("FAIL beat%0d_write: got we=%b idx=%0d data=%h want we=1 idx=%0d data=%h",
                 k, data_we, data_idx, data_wdata, exp_idx(a, k), d);
      end
      checks++;
      if (crit_valid !== exp_crit(a, k) || (exp_crit(a, k) && crit_data !== d)) begin
        failures++;
        $display("FAIL beat%0d_crit: got crit=%b data=%h want crit=%b data=%h",
                 k, crit_valid, crit_data, exp_crit(a, k), d);
      end
      @(negedge clk);
    end
    mem_bus.mem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; miss_valid = 0; miss_addr = '0; lookup_valid = 0; hit0 = 0; hit1 = 0;
    v_way0 = 1; v_way1 = 1; mem_bus.mem_gnt = 0; mem_bus.mem_rvalid = 0; mem_bus.mem_rdata = '0;
    #12;
    checks++;
    if ({busy, way_we, way_valid, data_we, crit_valid, refill_done, mem_bus.mem_req} !== 8'h00 ||
        mem_bus.mem_addr !== 32'h0 || victim_way !== 1'b0 || way_tag !== 28'h0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b we=%b req=%b addr=%h victim=%b tag=%h want all 0",
               busy, way_we, mem_bus.mem_req, mem_bus.mem_addr, victim_way, way_tag);
    end
    @(negedge clk); rst_n = 1'b1;
    exp_lru = 1'b0;
  endtask

  task automatic test_invalid_victim();
    logic [31:0] a = 32'h9ABC_DEF4;
    start_miss(a, 1'b0, 1'b1, 1'b1); #1;
    checks++;
    if (way_we !== 2'b01 || way_valid !== 1'b0 || way_tag !== 28'h9ABCDEF || busy !== 1'b1 ||
        victim_way !== 1'b0) begin
      failures++;
      $display("FAIL inval_way0: got we=%b valid=%b tag=%h busy=%b victim=%b want 01/0/9abcdef/1/0",
               way_we, way_valid, way_tag, busy, victim_way);
    end
    @(negedge clk); #1;
    checks++;
    if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== exp_maddr(a)) begin
      failures++;
      $display("FAIL req_addr: got req=%b addr=%h want 1/%h", mem_bus.mem_req,
               mem_bus.mem_addr, exp_maddr(a));
    end
    @(negedge clk); mem_bus.mem_gnt = 1'b0;
    drive_fill(a, 32'h11, 0, 4, -1); #1;
    checks++;
    if (way_we !== 2'b01 || way_valid !== 1'b1 || refill_done !== 1'b1 || way_tag !== 28'h9ABCDEF) begin
      failures++;
      $display("FAIL commit_way0: got we=%b valid=%b done=%b tag=%h want 01/1/1/9abcdef",
               way_we, way_valid, refill_done, way_tag);
    end
    exp_lru = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0 || refill_done !== 1'b0) begin
      failures++; $display("FAIL idle_after_commit: got busy=%b done=%b want 0/0", busy, refill_done);
    end
  endtask

  task automatic test_lru_victim();
    logic [31:0] a = 32'hCCCC_CCC0;
    @(negedge clk); lookup_valid = 1; hit1 = 1; hit0 = 0;
    @(negedge clk); hit1 = 0; hit0 = 1;
    @(negedge clk); hit1 = 1;
    @(negedge clk); lookup_valid = 0; hit0 = 0; hit1 = 0;
    exp_lru = 1'b1;
    start_miss(a, 1'b1, 1'b1, 1'b1); #1;
    checks++;
    if (victim_way !== 1'b1 || way_we !== 2'b10) begin
      failures++; $display("FAIL lru_victim: got victim=%b we=%b want 1/10", victim_way, way_we);
    end
    @(negedge clk);
    @(negedge clk); mem_bus.mem_gnt = 1'b0;
    drive_fill(a, 32'h5, 0, 4, -1); #1;
    checks++;
    if (way_we !== 2'b10 || way_valid !== 1'b1 || way_tag !== 28'hCCCCCCC) begin
      failures++;
      $display("FAIL commit_way1: got we=%b valid=%b tag=%h want 10/1/ccccccc", way_we, way_valid, way_tag);
    end
    exp_lru = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_grant_stall();
    logic [31:0] a = 32'h1234_5678;
    logic        v;
    int          we0;
    v = exp_victim(1'b1, 1'b1);
    start_miss(a, 1'b1, 1'b1, 1'b0); #1;
    checks++;
    if (victim_way !== v) begin
      failures++; $display("FAIL stall_victim: got %b want %b", victim_way, v);
    end
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      mem_bus.mem_rvalid = (i == 2);
      mem_bus.mem_gnt    = (i == 5);
      #1;
      checks++;
      if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== exp_maddr(a) || data_we !== 1'b0) begin
        failures++;
        $display("FAIL req_cycle%0d: got req=%b addr=%h we=%b want 1/%h/0", i, mem_bus.mem_req,
                 mem_bus.mem_addr, data_we, exp_maddr(a));
      end
      @(negedge clk);
    end
    mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0; #1;
    checks++;
    if (mem_bus.mem_req !== 1'b0) begin
      failures++; $display("FAIL req_drop: got %b want 0", mem_bus.mem_req);
    end
    we0 = we_cnt;
    drive_fill(a, 32'h1000, 0, 4, 2); #1;
    checks++;
    if (we_cnt - we0 !== 4 || refill_done !== 1'b1) begin
      failures++; $display("FAIL stall_pulses: got we=%0d done=%b want 4/1", we_cnt - we0, refill_done);
    end
    exp_lru = ~v;
    @(negedge clk);
  endtask

  task automatic test_critical_word();
    logic [31:0] a = 32'h0000_0038;
    int          c0;
    start_miss(a, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk); mem_bus.mem_gnt = 1'b0;
    c0 = crit_cnt;
    drive_fill(a, 32'hA0, 0, 4, -1); #1;
    checks++;
    if (crit_cnt - c0 !== 1 || refill_done !== 1'b1) begin
      failures++; $display("FAIL crit_count: got %0d done=%b want 1/1", crit_cnt - c0, refill_done);
    end
    exp_lru = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] a = 32'h0000_0040;
    start_miss(32'h0000_0080, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk); mem_bus.mem_gnt = 1'b0;
    drive_fill(32'h0000_0080, 32'h7, 0, 2, -1);
    #1 rst_n = 1'b0; #1;
    checks++;
    if (busy !== 1'b0 || mem_bus.mem_req !== 1'b0 || way_we !== 2'b00 || victim_way !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got busy=%b req=%b we=%b victim=%b want 0/0/00/0",
               busy, mem_bus.mem_req, way_we, victim_way);
    end
    exp_lru = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    start_miss(a, 1'b1, 1'b1, 1'b1); #1;
    checks++;
    if (way_we !== 2'b01 || way_valid !== 1'b0 || victim_way !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL fresh_inval: got we=%b valid=%b victim=%b busy=%b want 01/0/0/1",
               way_we, way_valid, victim_way, busy);
    end
    @(negedge clk);
    @(negedge clk); mem_bus.mem_gnt = 1'b0;
    drive_fill(a, 32'h9, 0, 4, -1); #1;
    checks++;
    if (refill_done !== 1'b1 || way_we !== 2'b01) begin
      failures++; $display("FAIL fresh_commit: got done=%b we=%b want 1/01", refill_done, way_we);
    end
    exp_lru = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_busy_filter();
    logic [31:0] a = 32'h0000_0200;
    start_miss(a, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk); mem_bus.mem_gnt = 1'b0;
    drive_fill(a, 32'h3, 0, 1, -1);
    miss_valid = 1; lookup_valid = 1; hit1 = 1;
    @(negedge clk);
    miss_valid = 0; lookup_valid = 0; hit1 = 0; #1;
    checks++;
    if (dut.lru !== exp_lru || busy !== 1'b1) begin
      failures++; $display("FAIL busy_lru_hold: got lru=%b busy=%b want %b/1", dut.lru, busy, exp_lru);
    end
    @(negedge clk);
    drive_fill(a, 32'h3, 1, 4, -1); #1;
    checks++;
    if (refill_done !== 1'b1 || way_we !== 2'b10) begin
      failures++; $display("FAIL busy_commit: got done=%b we=%b want 1/10", refill_done, way_we);
    end
    exp_lru = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0 || dut.lru !== exp_lru) begin
      failures++; $display("FAIL post_commit: got busy=%b lru=%b want 0/%b", busy, dut.lru, exp_lru);
    end
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0 || way_we !== 2'b00) begin
      failures++; $display("FAIL no_second_refill: got busy=%b we=%b want 0/00", busy, way_we);
    end
  endtask

  initial begin
    test_reset();
    test_invalid_victim();
    test_lru_victim();
    test_grant_stall();
    test_critical_word();
    test_reset_mid_fill();
    test_busy_filter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
- Miss-side counterpart to the 2-way hit-detection logic.
- When a lookup misses (hit_all=0), this block:
  - selects a victim way,
  - invalidates it,
  - fetches a 4-word line (4 x 32-bit) from memory with a req/gnt + rvalid protocol,
  - writes the data words, then commits tag (28 bits) and valid=1 to the victim way.
- Owns the single LRU bit for the 2 lines.

Parameters:
- TAG_W, 28, tag width; tag = addr[31:4].
- DATA_W, 32, memory beat / data word width.
- BEATS, 4, words per line; word index = addr[3:2]. Fixed at 4.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- miss_valid  in  1  lookup missed; sampled only in IDLE
- miss_addr  in  32  byte address of the missing access
- lookup_valid  in  1  a lookup completed this cycle (LRU update source)
- hit0  in  1  lookup hit way0
- hit1  in  1  lookup hit way1
- v_way0  in  1  current valid bit of way0
- v_way1  in  1  current valid bit of way1
- busy  out  1  state != IDLE; the lookup stage stalls on it
- victim_way  out  1  way being refilled; holds last value when idle
- way_we  out  2  one-hot tag/valid write strobe
- way_tag  out  TAG_W  tag to write
- way_valid  out  1  valid value to write
- data_we  out  1  data word write strobe
- data_idx  out  2  word index being written
- data_wdata  out  DATA_W  word being written
- mem_req  out  1  line read request
- mem_addr  out  32  request address
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  read beat valid
- mem_rdata  in  DATA_W  read beat data
- crit_valid  out  1  one-cycle pulse: the missed word is on crit_data
- crit_data  out  DATA_W  missed word (equals mem_rdata during the pulse)
- refill_done  out  1  one-cycle pulse in the COMMIT cycle

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, lru=0, beat counter=0.
  - All strobes/pulses 0, mem_addr=0, victim_way=0, way_tag=0, way_valid=0.
- States: IDLE -> INVAL -> REQ -> FILL -> COMMIT -> IDLE.
- IDLE:
  - On miss_valid=1 at a rising edge: latch miss_addr, go to INVAL.
  - Victim is latched on the same edge:
    - v_way0=0 -> way0;
    - else v_way1=0 -> way1;
    - else way `lru`.
- INVAL (1 cycle): way_we[victim]=1, way_valid=0, way_tag=latched tag. This prevents hits on a half-filled line.
- REQ:
  - mem_req=1 with mem_addr stable until mem_gnt=1 is sampled, then go to FILL.
  - mem_req drops in the cycle after grant.
  - mem_rvalid outside FILL is ignored.
- FILL:
  - Each cycle with mem_rvalid=1 is combinational write-through: data_we=1, data_idx=current beat index, data_wdata=mem_rdata.
  - The counter advances on each beat; after the 4th beat, go to COMMIT.
  - Gaps (mem_rvalid=0) are allowed without limit.
- COMMIT (1 cycle):
  - way_we[victim]=1, way_valid=1, way_tag=latched tag.
  - refill_done=1.
  - lru <= ~victim, so the filled way becomes MRU. Then go to IDLE.
- LRU update from lookups, only in IDLE:
  - lookup_valid & hit0 -> lru<=1.
  - lookup_valid & hit1 -> lru<=0.
  - hit0 & hit1 together -> lru unchanged.
- Lookup updates and miss_valid are ignored while busy=1.
- If a miss and a lookup-hit update coincide in IDLE, the miss victim uses the pre-edge lru.
- Minimum latency, with miss sampled at edge 0, grant in the first REQ cycle and back-to-back beats:
  - INVAL in cycle 0-1;
  - mem_req in cycle 1-2;
  - beats in cycles 2..5;
  - COMMIT in cycle 6;
  - busy=0 from cycle 7.
- Reset mid-refill: immediate return to IDLE. The victim line stays invalid because INVAL has already been written, or was never touched.

Optional Feature:
- Macro: CRITICAL_WORD_FIRST_EN.
- Defined:
  - mem_addr = miss_addr with bits [1:0] cleared.
  - Beat k writes index (miss_addr[3:2]+k) mod 4, wrapping 3->0.
  - crit_valid pulses on beat 0.
- Undefined:
  - mem_addr = line-aligned (bits [3:0] cleared).
  - Beat k writes index k.
  - crit_valid pulses on the beat whose index equals miss_addr[3:2].

Test Plan:
- Invalid victim:
  - Stimulus: v_way0=0, v_way1=1; miss_addr=0x9ABCDEF4; gnt immediate; beats 0x11,0x22,0x33,0x44.
  - Response: INVAL write way0 valid=0 tag 0x9ABCDEF; data idx 0..3 (macro off); COMMIT way_we=01, valid=1; refill_done after 7 cycles.
- LRU victim:
  - Stimulus: both ways valid; lookup hit0 in IDLE; miss to 0xCCCCCCC0.
  - Response: lru=1 -> victim way1, way_we=10; after COMMIT lru=0.
- Grant stall and beat gaps:
  - Stimulus: mem_gnt held 0 for 5 cycles; one idle cycle between beats 2 and 3.
  - Response: mem_req high 6 cycles with mem_addr stable; exactly 4 data_we pulses; a stray mem_rvalid during REQ is ignored.
- Critical word:
  - Stimulus: miss_addr=0x0000_0038 (word 2).
  - Response, macro on: idx order 2,3,0,1 and crit_valid on the first beat.
  - Response, macro off: idx order 0,1,2,3 and crit_valid on the third beat.
- Reset mid-FILL:
  - Stimulus: rst_n=0 after 2 beats.
  - Response: busy=0, mem_req=0, lru=0 asynchronously; next miss_valid starts a fresh INVAL.
- Busy filtering:
  - Stimulus: miss_valid and lookup_valid&hit1 pulses during FILL.
  - Response: no second refill, lru unchanged until COMMIT.
